// File: rtl/reaction_timer.sv
// Reaction-time game engine: pseudo-random pre-go delay, then a millisecond count until the press.
// Reports the measured time, an early press or a timeout. iAbort returns to IDLE and iReset clears everything.
module reaction_timer #(
  parameter int unsigned TICKS_PER_MS    = 50000,
  parameter int unsigned MIN_DELAY_MS    = 1000,
  parameter int unsigned DELAY_SPAN_LOG2 = 11,
  parameter int unsigned MAX_MS          = 9999
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iStart,
  input  logic        iAbort,
  input  logic        iPress,
  output logic [2:0]  oState,
  output logic        oGo,
  output logic [13:0] oTimeMs,
  output logic        oDone,
  output logic        oEarly,
  output logic        oTimeout
);

  localparam int unsigned PS_W    = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int unsigned DLY_MAX = MIN_DELAY_MS + (2 ** DELAY_SPAN_LOG2) - 1;
  localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_GO      = 3'd2,
    S_RESULT  = 3'd3,
    S_EARLY   = 3'd4,
    S_TIMEOUT = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [PS_W-1:0]   ps_q, ps_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [13:0]       time_q, time_d;
  logic              done_q, done_d;
  logic              tick;
  logic              start_trial;

  assign tick = (ps_q == PS_W'(TICKS_PER_MS - 1));

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q <= S_IDLE;
      lfsr_q  <= 16'hACE1;
      ps_q    <= '0;
      dly_q   <= '0;
      time_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      ps_q    <= ps_d;
      dly_q   <= dly_d;
      time_q  <= time_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    time_d      = time_q;
    done_d      = 1'b0;
    start_trial = 1'b0;
    lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    if (state_q == S_WAIT || state_q == S_GO) begin
      ps_d = tick ? '0 : ps_q + PS_W'(1);
    end else begin
      ps_d = '0;
    end

    if (iAbort) begin
      state_d = S_IDLE;
      time_d  = '0;
    end else if (iStart) begin
      start_trial = 1'b1;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (iPress) begin
            state_d = S_EARLY;
            done_d  = 1'b1;
          end else if (tick) begin
            if (dly_q <= DLY_W'(1)) begin
              state_d = S_GO;
              dly_d   = '0;
            end else begin
              dly_d = dly_q - DLY_W'(1);
            end
          end
        end
        S_GO: begin
          // A press wins over a coincident tick, so the frozen time is not bumped.
          if (iPress) begin
            state_d = S_RESULT;
            done_d  = 1'b1;
          end else if (tick) begin
            if (time_q >= 14'(MAX_MS)) begin
              state_d = S_TIMEOUT;
              time_d  = 14'(MAX_MS);
              done_d  = 1'b1;
            end else begin
              time_d = time_q + 14'd1;
            end
          end
        end
        S_RESULT, S_EARLY, S_TIMEOUT: begin
          if (iPress) start_trial = 1'b1;
        end
        default: ;
      endcase
    end

    if (start_trial) begin
      state_d = S_WAIT;
      dly_d   = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr_q[DELAY_SPAN_LOG2-1:0]);
      time_d  = '0;
    end

    // Every entry into a timed state starts on a fresh, full millisecond.
    if (start_trial || (state_d == S_GO && state_q != S_GO)) begin
      ps_d = '0;
    end
  end

  assign oState   = state_q;
  assign oGo      = (state_q == S_GO);
  assign oTimeMs  = time_q;
  assign oDone    = done_q;
  assign oEarly   = (state_q == S_EARLY);
  assign oTimeout = (state_q == S_TIMEOUT);

endmodule

// File: tb/tb_reaction_timer.sv
// Scoreboard bench for reaction_timer with small timing parameters.
module tb_reaction_timer;
  localparam int TPM   = 4;
  localparam int MIN   = 2;
  localparam int SPAN  = 2;
  localparam int MAXMS = 9;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_WAIT = 3'd1, ST_GO = 3'd2,
                         ST_RESULT = 3'd3, ST_EARLY = 3'd4, ST_TIMEOUT = 3'd5;

  logic        clk = 1'b0;
  logic        rst, start, abort, press;
  logic [2:0]  o_state;
  logic        o_go, o_done, o_early, o_timeout;
  logic [13:0] o_time;

  reaction_timer #(
    .TICKS_PER_MS(TPM), .MIN_DELAY_MS(MIN), .DELAY_SPAN_LOG2(SPAN), .MAX_MS(MAXMS)
  ) dut (
    .iClock(clk), .iReset(rst), .iStart(start), .iAbort(abort), .iPress(press),
    .oState(o_state), .oGo(o_go), .oTimeMs(o_time), .oDone(o_done),
    .oEarly(o_early), .oTimeout(o_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [13:0] t;
  } res_t;

  res_t        exp_q[$];
  res_t        exp_e;
  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  bit          go_seen  = 0;
  logic [15:0] lfsr_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic res_t mk(input logic [2:0] st, input logic [13:0] t);
    res_t r;
    r.st = st;
    r.t  = t;
    return r;
  endfunction

  // Reference LFSR: 16-bit Galois, mask B400, seeded at reset.
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
  end

  always @(negedge clk) begin
    if (o_go) go_seen = 1;
    if (!rst && o_done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_e = exp_q.pop_front();
        check("sb_state", o_state, exp_e.st);
        check("sb_time", o_time, exp_e.t);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_press();
    press = 1'b1; step(); press = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic wait_go(output int n);
    n = 0;
    while (!o_go && n < 200) begin step(); n++; end
    if (!o_go) check("go_timeout", 0, 1);
  endtask

  task automatic wait_time(input logic [13:0] v);
    int n;
    n = 0;
    while (o_time != v && n < 200) begin step(); n++; end
    if (o_time != v) check("time_wait_timeout", o_time, v);
  endtask

  initial begin
    int n, dly, d0, prev, bad, cyc;

    rst = 1'b1; start = 1'b0; abort = 1'b0; press = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", o_state, ST_IDLE);
    check("rst_outs", {o_go, o_done, o_early, o_timeout}, 0);
    check("rst_time", o_time, 0);
    rst = 1'b0;
    step();

    // 1: measured trial with latched LFSR[1:0]=1
    n = 0;
    while (lfsr_m[1:0] != 2'd1 && n < 64) begin step(); n++; end
    check("t1_lfsr_low", lfsr_m[1:0], 1);
    dly = MIN + int'(lfsr_m[1:0]);
    pulse_start();
    check("t1_wait", o_state, ST_WAIT);
    check("t1_wait_time", o_time, 0);
    wait_go(n);
    check("t1_wait_len", n, TPM * dly);
    check("t1_go_state", o_state, ST_GO);
    wait_time(14'd5);
    d0 = done_cnt;
    exp_q.push_back(mk(ST_RESULT, 14'd5));
    pulse_press();
    check("t1_result", o_state, ST_RESULT);
    check("t1_done", o_done, 1);
    check("t1_go_off", o_go, 0);
    step(); step();
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_hold", o_time, 5);

    // 2: early press
    go_seen = 0;
    pulse_start();
    repeat (3) step();
    exp_q.push_back(mk(ST_EARLY, 14'd0));
    pulse_press();
    check("t2_early_state", o_state, ST_EARLY);
    check("t2_early_flag", o_early, 1);
    check("t2_time", o_time, 0);
    repeat (20) step();
    check("t2_no_go", go_seen, 0);
    check("t2_stays", o_state, ST_EARLY);

    // 3: timeout
    pulse_start();
    wait_go(n);
    d0 = done_cnt;
    exp_q.push_back(mk(ST_TIMEOUT, 14'(MAXMS)));
    prev = 0; bad = 0; cyc = 0;
    while (!o_timeout && cyc < 200) begin
      step(); cyc++;
      if (!o_timeout && int'(o_time) != prev) begin
        if (int'(o_time) != prev + 1) bad++;
        prev = int'(o_time);
      end
    end
    check("t3_incr", bad, 0);
    check("t3_last_live", prev, MAXMS);
    check("t3_go_cycles", cyc, TPM * (MAXMS + 1));
    check("t3_flag", o_timeout, 1);
    check("t3_time", o_time, MAXMS);
    check("t3_done", o_done, 1);
    step(); step();
    check("t3_done_once", done_cnt - d0, 1);
    check("t3_hold", o_time, MAXMS);

    // 4: press coinciding with a tick; press in first GO cycle
    pulse_start();
    wait_go(n);
    wait_time(14'd3);
    repeat (3) step();
    exp_q.push_back(mk(ST_RESULT, 14'd3));
    pulse_press();
    check("t4_tick_press_state", o_state, ST_RESULT);
    check("t4_tick_press_time", o_time, 3);
    pulse_start();
    wait_go(n);
    exp_q.push_back(mk(ST_RESULT, 14'd0));
    pulse_press();
    check("t4_first_cycle_state", o_state, ST_RESULT);
    check("t4_first_cycle_time", o_time, 0);

    // 5: start+abort together, press ignored in IDLE, press restarts from RESULT
    pulse_start();
    wait_go(n);
    wait_time(14'd2);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("t5_abort_state", o_state, ST_IDLE);
    check("t5_abort_outs", {o_go, o_done, o_early, o_timeout}, 0);
    check("t5_abort_time", o_time, 0);
    pulse_press();
    check("t5_idle_ignores_press", o_state, ST_IDLE);
    pulse_start();
    wait_go(n);
    wait_time(14'd1);
    exp_q.push_back(mk(ST_RESULT, 14'd1));
    pulse_press();
    check("t5_result", o_state, ST_RESULT);
    step();
    pulse_press();
    check("t5_restart_state", o_state, ST_WAIT);
    check("t5_restart_time", o_time, 0);
    pulse_abort();
    check("t5_abort2", o_state, ST_IDLE);

    // 6: async reset mid-GO
    pulse_start();
    wait_go(n);
    wait_time(14'd2);
    #2;
    rst = 1'b1;
    #1;
    check("t6_state", o_state, ST_IDLE);
    check("t6_outs", {o_go, o_done, o_early, o_timeout}, 0);
    check("t6_time", o_time, 0);
    check("t6_lfsr", dut.lfsr_q, 16'hACE1);
    step();
    rst = 1'b0;
    repeat (3) step();
    check("t6_after", o_state, ST_IDLE);
    check("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
